// File: rtl/sys_issue_queue.sv
// In-order issue queue for the system FU: each op waits until its tag is at the ROB head.
// Define SYS_ISSUE_QUEUE_STATS_EN to add saturating issue/stall counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module sys_issue_queue #(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned OP_W       = 16,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enq_valid,
    output logic                  o_enq_ready,
    input  logic [OP_W-1:0]       i_enq_op,
    input  logic [DATA_WIDTH-1:0] i_enq_src1,
    input  logic [DATA_WIDTH-1:0] i_enq_src2,
    input  logic [TAG_W-1:0]      i_enq_tag,
    input  logic [TAG_W-1:0]      i_rob_head_tag,
    input  logic                  i_flush,
    output logic                  o_fu_enabled,
    output logic [OP_W-1:0]       o_fu_op,
    output logic [DATA_WIDTH-1:0] o_fu_src1,
    output logic [DATA_WIDTH-1:0] o_fu_src2,
    input  logic [DATA_WIDTH-1:0] i_fu_dest,
    output logic                  o_wb_valid,
    output logic [TAG_W-1:0]      o_wb_tag,
    output logic [DATA_WIDTH-1:0] o_wb_data,
`ifdef SYS_ISSUE_QUEUE_STATS_EN
    output logic [31:0]           o_stat_issued,
    output logic [31:0]           o_stat_stall,
`endif
    input  logic                  i_wb_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [DATA_WIDTH-1:0] src1;
        logic [DATA_WIDTH-1:0] src2;
        logic [TAG_W-1:0]      tag;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StWb} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TAG_W-1:0]      wb_tag_q, wb_tag_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    entry_t                mem_q [DEPTH];
    entry_t                head;
    logic                  enq_fire;
    logic                  pop;
    logic                  head_match;

    assign head        = mem_q[rd_ptr_q];
    // Ready is purely from the registered count; a pop in the same cycle does not help.
    assign o_enq_ready = (count_q < CNT_W'(DEPTH));
    assign enq_fire    = i_enq_valid & o_enq_ready & ~i_flush;
    assign head_match  = (count_q != '0) && (head.tag == i_rob_head_tag);
    assign pop         = (state_q == StCapture) && !i_flush;

    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wb_tag_d  = wb_tag_q;
        wb_data_d = wb_data_q;
        if (i_flush) begin
            state_d  = StIdle;
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            unique case (state_q)
                StIdle:    if (head_match) state_d = StIssue;
                StIssue:   state_d = StCapture;
                StCapture: begin
                    state_d   = StWb;
                    wb_tag_d  = head.tag;
                    wb_data_d = i_fu_dest;
                end
                StWb:      if (i_wb_ready) state_d = StIdle;
                default:   state_d = StIdle;
            endcase
            if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({enq_fire, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wb_tag_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wb_tag_q  <= wb_tag_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge i_clk) begin
        if (enq_fire) begin
            mem_q[wr_ptr_q] <= '{op: i_enq_op, src1: i_enq_src1, src2: i_enq_src2, tag: i_enq_tag};
        end
    end

    always_comb begin
        o_fu_enabled = 1'b0;
        o_fu_op      = '0;
        o_fu_src1    = '0;
        o_fu_src2    = '0;
        if (state_q == StIssue) begin
            o_fu_enabled = 1'b1;
            o_fu_op      = head.op;
            o_fu_src1    = head.src1;
            o_fu_src2    = head.src2;
        end
    end

    assign o_wb_valid = (state_q == StWb);
    assign o_wb_tag   = wb_tag_q;
    assign o_wb_data  = wb_data_q;

`ifdef SYS_ISSUE_QUEUE_STATS_EN
    logic [31:0] stat_issued_q;
    logic [31:0] stat_stall_q;

    // Counters survive flushes and saturate instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (state_q == StIssue && stat_issued_q != '1) begin
                stat_issued_q <= stat_issued_q + 32'd1;
            end
            if (state_q == StIdle && count_q != '0 && !head_match && stat_stall_q != '1) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign o_stat_issued = stat_issued_q;
    assign o_stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_sys_issue_queue.sv
// Self-checking bench for sys_issue_queue: directed scenarios with random payloads
// checked against a queue-based reference model.
`timescale 1ns/1ps

module tb_sys_issue_queue;

    localparam int unsigned DW    = 64;
    localparam int unsigned OPW   = 16;
    localparam int unsigned TW    = 6;
    localparam int unsigned DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enq_valid = 1'b0;
    logic           enq_ready;
    logic [OPW-1:0] enq_op = '0;
    logic [DW-1:0]  enq_src1 = '0;
    logic [DW-1:0]  enq_src2 = '0;
    logic [TW-1:0]  enq_tag = '0;
    logic [TW-1:0]  rob_head = '0;
    logic           flush = 1'b0;
    logic           fu_en;
    logic [OPW-1:0] fu_op;
    logic [DW-1:0]  fu_src1;
    logic [DW-1:0]  fu_src2;
    logic [DW-1:0]  fu_dest = '0;
    logic           wb_valid;
    logic [TW-1:0]  wb_tag;
    logic [DW-1:0]  wb_data;
    logic           wb_ready = 1'b0;
`ifdef SYS_ISSUE_QUEUE_STATS_EN
    logic [31:0]    stat_issued;
    logic [31:0]    stat_stall;
`endif

    sys_issue_queue #(
        .DATA_WIDTH(DW),
        .OP_W      (OPW),
        .TAG_W     (TW),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enq_valid   (enq_valid),
        .o_enq_ready   (enq_ready),
        .i_enq_op      (enq_op),
        .i_enq_src1    (enq_src1),
        .i_enq_src2    (enq_src2),
        .i_enq_tag     (enq_tag),
        .i_rob_head_tag(rob_head),
        .i_flush       (flush),
        .o_fu_enabled  (fu_en),
        .o_fu_op       (fu_op),
        .o_fu_src1     (fu_src1),
        .o_fu_src2     (fu_src2),
        .i_fu_dest     (fu_dest),
        .o_wb_valid    (wb_valid),
        .o_wb_tag      (wb_tag),
        .o_wb_data     (wb_data),
`ifdef SYS_ISSUE_QUEUE_STATS_EN
        .o_stat_issued (stat_issued),
        .o_stat_stall  (stat_stall),
`endif
        .i_wb_ready    (wb_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OPW-1:0] op;
        logic [DW-1:0]  s1;
        logic [DW-1:0]  s2;
        logic [TW-1:0]  tag;
    } op_t;

    op_t         model_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned issue_seen = 0;

    function automatic logic [DW-1:0] fu_fn(input logic [OPW-1:0] op, input logic [DW-1:0] s1,
                                            input logic [DW-1:0] s2);
        return (s1 + (s2 << 1)) ^ {{(DW-OPW){1'b0}}, op};
    endfunction

    function automatic op_t rand_op(input logic [TW-1:0] tag);
        op_t e;
        e.op  = OPW'($urandom);
        e.s1  = {$urandom, $urandom};
        e.s2  = {$urandom, $urandom};
        e.tag = tag;
        return e;
    endfunction

    // FU stand-in: result valid the cycle after the enable, random noise otherwise
    always @(posedge clk) begin
        if (fu_en) begin
            fu_dest    <= fu_fn(fu_op, fu_src1, fu_src2);
            issue_seen <= issue_seen + 1;
        end else begin
            fu_dest <= {$urandom, $urandom};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input op_t e);
        enq_valid = 1'b1;
        enq_op    = e.op;
        enq_src1  = e.s1;
        enq_src2  = e.s2;
        enq_tag   = e.tag;
        tick();
        enq_valid = 1'b0;
        model_q.push_back(e);
    endtask

    task automatic ack_wb;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic wait_fu(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (fu_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wb_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready: got %0h want 1", enq_ready); end
        checks++; if (fu_en !== 1'b0) begin errors++; $display("FAIL reset_fu_en: got %0h want 0", fu_en); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0h want 0", wb_valid); end
        checks++; if (wb_tag !== '0) begin errors++; $display("FAIL reset_wb_tag: got %0h want 0", wb_tag); end
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %0h want 0", wb_data); end
        checks++; if (fu_src1 !== '0 || fu_op !== '0) begin errors++; $display("FAIL reset_fu_bus: got %0h/%0h want 0", fu_op, fu_src1); end
`ifdef SYS_ISSUE_QUEUE_STATS_EN
        checks++; if (stat_issued !== '0 || stat_stall !== '0) begin errors++; $display("FAIL reset_stats: got %0h/%0h want 0", stat_issued, stat_stall); end
`endif
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            checks++; if (fu_en !== 1'b0) begin errors++; $display("FAIL idle_no_issue: got %0h want 0", fu_en); end
        end
    endtask

    task automatic test_single_op;
        op_t e;
        e = '{op: 16'hAB9D, s1: 64'h10, s2: 64'h20, tag: 6'd5};
        rob_head = 6'd5;
        push_op(e);
        checks++; if (fu_en !== 1'b0) begin errors++; $display("FAIL single_no_same_cycle: got %0h want 0", fu_en); end
        tick();
        checks++; if (fu_en !== 1'b1) begin errors++; $display("FAIL single_fu_en: got %0h want 1", fu_en); end
        checks++; if (fu_src1 !== 64'h10 || fu_src2 !== 64'h20) begin errors++; $display("FAIL single_fu_src: got %0h/%0h want 10/20", fu_src1, fu_src2); end
        checks++; if (fu_op !== 16'hAB9D) begin errors++; $display("FAIL single_fu_op: got %0h want ab9d", fu_op); end
        tick();
        checks++; if (fu_en !== 1'b0 || fu_src1 !== '0) begin errors++; $display("FAIL single_pulse_width: got %0h/%0h want 0/0", fu_en, fu_src1); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_early: got %0h want 0", wb_valid); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %0h want 1", wb_valid); end
        checks++; if (wb_tag !== 6'd5) begin errors++; $display("FAIL single_wb_tag: got %0h want 5", wb_tag); end
        checks++; if (wb_data !== 64'hABCD) begin errors++; $display("FAIL single_wb_data: got %0h want abcd", wb_data); end
        ack_wb();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_drop: got %0h want 0", wb_valid); end
        void'(model_q.pop_front());
    endtask

    task automatic test_serialisation;
        bit  ok;
        op_t cur;
        rob_head = 6'd2;
        push_op(rand_op(6'd3));
        push_op(rand_op(6'd4));
        repeat (8) begin
            checks++; if (fu_en !== 1'b0) begin errors++; $display("FAIL serial_hold: got %0h want 0", fu_en); end
            tick();
        end
        for (int t = 3; t <= 4; t++) begin
            rob_head = TW'(t);
            wait_wb(ok);
            cur = model_q.pop_front();
            checks++; if (!ok) begin errors++; $display("FAIL serial_wb_timeout: got none want tag %0d", t); end
            checks++; if (wb_tag !== cur.tag || wb_data !== fu_fn(cur.op, cur.s1, cur.s2)) begin
                errors++; $display("FAIL serial_wb: got %0h/%0h want %0h/%0h", wb_tag, wb_data, cur.tag, fu_fn(cur.op, cur.s1, cur.s2)); end
            ack_wb();
            if (t == 3) begin
                repeat (8) begin
                    checks++; if (fu_en !== 1'b0) begin errors++; $display("FAIL serial_next_held: got %0h want 0", fu_en); end
                    tick();
                end
            end
        end
    endtask

    task automatic test_full_backpressure;
        bit            ok;
        logic          rdy_prev;
        op_t           cur;
        logic [DW-1:0] exp_data;
        rob_head = 6'd63;
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_ready_early: got %0h want 1", enq_ready); end
            push_op(rand_op(TW'(10 + i)));
        end
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0h want 0", enq_ready); end
        enq_valid = 1'b1;
        enq_tag   = 6'd14;
        tick();
        enq_valid = 1'b0;
        rob_head  = 6'd10;
        rdy_prev  = 1'b1;
        ok        = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (wb_valid) begin
                ok = 1'b1;
                break;
            end
            rdy_prev = enq_ready;
            tick();
        end
        cur      = model_q.pop_front();
        exp_data = fu_fn(cur.op, cur.s1, cur.s2);
        checks++; if (!ok) begin errors++; $display("FAIL full_wb_timeout: got none want tag 10"); end
        checks++; if (rdy_prev !== 1'b0) begin errors++; $display("FAIL full_ready_pop_cycle: got %0h want 0", rdy_prev); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %0h want 1", enq_ready); end
        repeat (5) begin
            tick();
            checks++; if (wb_valid !== 1'b1 || wb_tag !== cur.tag || wb_data !== exp_data) begin
                errors++; $display("FAIL full_wb_stable: got %0h/%0h/%0h want 1/%0h/%0h", wb_valid, wb_tag, wb_data, cur.tag, exp_data); end
        end
        ack_wb();
        while (model_q.size() != 0) begin
            cur      = model_q.pop_front();
            rob_head = cur.tag;
            wait_wb(ok);
            checks++; if (!ok || wb_tag !== cur.tag || wb_data !== fu_fn(cur.op, cur.s1, cur.s2)) begin
                errors++; $display("FAIL full_drain: got %0h/%0h want %0h/%0h", wb_tag, wb_data, cur.tag, fu_fn(cur.op, cur.s1, cur.s2)); end
            ack_wb();
        end
        rob_head = 6'd14;
        repeat (10) begin
            checks++; if (fu_en !== 1'b0) begin errors++; $display("FAIL full_dropped_enq: got %0h want 0", fu_en); end
            tick();
        end
    endtask

    task automatic test_wrap;
        bit  ok;
        op_t cur;
        op_t nxt;
        int  next_tag;
        rob_head = 6'd63;
        for (int i = 0; i < 3; i++) push_op(rand_op(TW'(i)));
        next_tag = 3;
        for (int t = 0; t < 10; t++) begin
            rob_head = TW'(t);
            wait_fu(ok);
            cur = model_q.pop_front();
            checks++; if (!ok || fu_op !== cur.op || fu_src1 !== cur.s1 || fu_src2 !== cur.s2) begin
                errors++; $display("FAIL wrap_issue: got %0h/%0h/%0h want %0h/%0h/%0h", fu_op, fu_src1, fu_src2, cur.op, cur.s1, cur.s2); end
            tick();
            // enqueue lands on the same edge as the pop
            if (next_tag < 10) begin
                nxt = rand_op(TW'(next_tag));
                push_op(nxt);
                next_tag++;
            end else begin
                tick();
            end
            checks++; if (wb_valid !== 1'b1 || wb_tag !== cur.tag || wb_data !== fu_fn(cur.op, cur.s1, cur.s2)) begin
                errors++; $display("FAIL wrap_wb: got %0h/%0h/%0h want 1/%0h/%0h", wb_valid, wb_tag, wb_data, cur.tag, fu_fn(cur.op, cur.s1, cur.s2)); end
            ack_wb();
        end
    endtask

    task automatic test_flush_capture;
        bit  ok;
        op_t cur;
        rob_head = 6'd63;
        for (int i = 0; i < 3; i++) push_op(rand_op(TW'(20 + i)));
        rob_head = 6'd20;
        wait_fu(ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_issue_timeout: got none want tag 20"); end
        tick();
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_tag   = 6'd23;
        tick();
        flush     = 1'b0;
        enq_valid = 1'b0;
        model_q.delete();
        checks++; if (wb_valid !== 1'b0 || fu_en !== 1'b0) begin errors++; $display("FAIL flush_outputs: got %0h/%0h want 0/0", wb_valid, fu_en); end
        checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0h want 1", enq_ready); end
        for (int h = 20; h <= 23; h++) begin
            rob_head = TW'(h);
            repeat (5) begin
                checks++; if (fu_en !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0h/%0h want 0/0", fu_en, wb_valid); end
                tick();
            end
        end
        rob_head = 6'd63;
        for (int i = 0; i < DEPTH; i++) push_op(rand_op(TW'(30 + i)));
        checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL flush_refill_full: got %0h want 0", enq_ready); end
        while (model_q.size() != 0) begin
            cur      = model_q.pop_front();
            rob_head = cur.tag;
            wait_wb(ok);
            checks++; if (!ok || wb_tag !== cur.tag || wb_data !== fu_fn(cur.op, cur.s1, cur.s2)) begin
                errors++; $display("FAIL flush_after_op: got %0h/%0h want %0h/%0h", wb_tag, wb_data, cur.tag, fu_fn(cur.op, cur.s1, cur.s2)); end
            ack_wb();
        end
    endtask

    task automatic test_flush_wb;
        bit ok;
        rob_head = 6'd40;
        push_op(rand_op(6'd40));
        wait_wb(ok);
        checks++; if (!ok) begin errors++; $display("FAIL flushwb_timeout: got none want tag 40"); end
        flush    = 1'b1;
        wb_ready = 1'b1;
        tick();
        flush    = 1'b0;
        wb_ready = 1'b0;
        model_q.delete();
        repeat (5) begin
            checks++; if (wb_valid !== 1'b0 || fu_en !== 1'b0) begin errors++; $display("FAIL flushwb_dropped: got %0h/%0h want 0/0", wb_valid, fu_en); end
            tick();
        end
`ifdef SYS_ISSUE_QUEUE_STATS_EN
        checks++; if (stat_issued !== 32'(issue_seen)) begin errors++; $display("FAIL stat_issued: got %0d want %0d", stat_issued, issue_seen); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_serialisation();
        test_full_backpressure();
        test_wrap();
        test_flush_capture();
        test_flush_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sys_issue_queue.md
Name: sys_issue_queue

Overview:
- Upstream feeder for the system functional unit (sys_unit).
- Buffers decoded system ops from dispatch in a small in-order FIFO.
- Holds each op until its ROB tag reaches the ROB head (system ops execute non-speculatively and serialised), then pulses the FU enable for one cycle.
- Captures the FU result one cycle later and presents it to writeback with a valid/ready handshake.

Parameters:
- DATA_WIDTH, `DATA_WIDTH (64), operand/result width.
- OP_W, 16, width of the packed decoded op field.
- TAG_W, 6, ROB tag width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_enq_valid  in  1  dispatch offers an op.
- o_enq_ready  out  1  queue can accept; = (count < DEPTH).
- i_enq_op  in  OP_W  decoded op.
- i_enq_src1  in  DATA_WIDTH  operand 1.
- i_enq_src2  in  DATA_WIDTH  operand 2.
- i_enq_tag  in  TAG_W  ROB tag.
- i_rob_head_tag  in  TAG_W  tag currently at ROB head.
- i_flush  in  1  pipeline flush.
- o_fu_enabled  out  1  one-cycle issue pulse to the sys unit.
- o_fu_op  out  OP_W  op to the FU.
- o_fu_src1  out  DATA_WIDTH  operand 1 to the FU.
- o_fu_src2  out  DATA_WIDTH  operand 2 to the FU.
- i_fu_dest  in  DATA_WIDTH  FU result, valid the cycle after o_fu_enabled.
- o_wb_valid  out  1  result available.
- o_wb_tag  out  TAG_W  ROB tag of the result.
- o_wb_data  out  DATA_WIDTH  result data.
- i_wb_ready  in  1  writeback accepts.

Behaviour:
- Reset (async, i_rst_n=0): count, rd_ptr, wr_ptr = 0; state = IDLE; all outputs 0 except o_enq_ready = 1. Reset mid-operation discards everything, including any in-flight FU result.
- Enqueue: entry written at the clock edge when i_enq_valid & o_enq_ready & ~i_flush. wr_ptr wraps modulo DEPTH.
- o_enq_ready comes from the registered count only. No same-cycle bypass of a pop, so a full queue stays not-ready during the pop cycle.
- FSM states:
  - IDLE -> ISSUE when count != 0 and head.tag == i_rob_head_tag.
  - ISSUE -> CAPTURE unconditionally. In ISSUE, o_fu_enabled = 1 and o_fu_op/src1/src2 = head entry.
  - CAPTURE: at the end of the cycle, latch i_fu_dest into o_wb_data and head.tag into o_wb_tag; pop the head (rd_ptr++, count--); go to WB.
  - WB: o_wb_valid = 1; data and tag are held stable while i_wb_ready = 0. On i_wb_ready = 1 -> IDLE.
- Outside ISSUE: o_fu_enabled = 0 and o_fu_op/src = 0.
- Latency: tag match sampled in cycle T gives o_fu_enabled at T+1 and o_wb_valid at T+3. Peak throughput is one op per 4 cycles.
- Simultaneous enqueue and pop: count is unchanged, and both pointers advance.
- Enqueue into an empty queue whose tag already equals i_rob_head_tag: the match is seen the following cycle, with no same-cycle issue.
- i_flush, checked in priority over everything else at the edge:
  - queue emptied (count = 0, rd_ptr = wr_ptr); state -> IDLE.
  - o_wb_valid cleared; any enqueue that cycle is dropped.
  - a flush during CAPTURE discards the FU result.
  - a flush in WB with i_wb_ready = 1 still drops the result; the handshake is not completed.
- Count width is $clog2(DEPTH)+1; full when count == DEPTH.

Optional Feature:
- Macro SYS_ISSUE_QUEUE_STATS_EN.
- When defined, adds two outputs:
  - o_stat_issued [31:0]: increments on each ISSUE cycle.
  - o_stat_stall [31:0]: increments on each IDLE cycle with count != 0 and no tag match.
- Both counters saturate at all-ones, clear on reset only (not on flush), and reset to 0.
- When not defined, the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold i_rst_n = 0, then release -> o_enq_ready = 1, all other outputs 0, no o_fu_enabled for 10 cycles with an empty queue.
- Single op: enqueue tag 5, src1 = 0x10, src2 = 0x20, i_rob_head_tag = 5, FU model returns 0xABCD -> o_fu_enabled for exactly 1 cycle carrying src 0x10/0x20; 2 cycles later o_wb_valid = 1, tag 5, data 0xABCD; drops 1 cycle after i_wb_ready = 1.
- Serialisation: enqueue tags 3, 4 with head tag = 2 for 8 cycles -> no issue. Set head = 3 -> tag 3 written back. Keep head = 3 -> tag 4 never issues until head = 4.
- Full/backpressure: enqueue DEPTH = 4 ops -> o_enq_ready = 0. Hold i_wb_ready = 0 -> o_wb_valid and data stay stable for 5 cycles. o_enq_ready returns 1 the cycle after the CAPTURE pop.
- Wrap-around: stream 10 ops, tags 0..9, with head tag following each -> results arrive in order with correct data; pointers wrap twice.
- Flush: flush asserted in CAPTURE with 3 entries queued and enq_valid high -> next cycle count = 0, o_wb_valid = 0, state IDLE, the flushed-cycle enqueue absent; a new op afterwards completes normally.
